// File: rtl/poly_pkg.sv
`default_nettype none
// ============================================================================
// Module   : poly_pkg
// Brief    : Shared types and defaults for the polynomial operand feeder.
// Revision : 1.0 - initial release
// ============================================================================
package poly_pkg;

    localparam int NUM_OPERANDS           = 4;
    localparam int DEFAULT_DATA_W         = 8;
    localparam int DEFAULT_COMPUTE_CYCLES = 5;
    localparam int STATE_W                = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_GO_HI   = 3'd1,
        ST_GO_LO   = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_HOLD    = 3'd5
    } state_t;

endpackage : poly_pkg
`default_nettype wire

// File: rtl/poly_feeder_if.sv
`default_nettype none
// ============================================================================
// Module   : poly_feeder_if
// Brief    : Upstream handshake, evaluator load bus and result handshake.
//            The slave modport is the feeder's view; master is the
//            surrounding system (source, evaluator and result consumer).
// Revision : 1.0 - initial release
// ============================================================================
interface poly_feeder_if #(
    parameter int DATA_W = poly_pkg::DEFAULT_DATA_W
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] c;
    logic [DATA_W-1:0] x;
    logic              go;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_result;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] result;
    logic              busy;

    modport slave (
        input  in_valid, a, b, c, x, data_result, out_ready,
        output in_ready, go, data_in, out_valid, result, busy
    );

    modport master (
        output in_valid, a, b, c, x, data_result, out_ready,
        input  in_ready, go, data_in, out_valid, result, busy
    );

endinterface : poly_feeder_if
`default_nettype wire

// File: rtl/poly_feeder_counter.sv
`default_nettype none
// ============================================================================
// Module   : poly_feeder_counter
// Brief    : Loadable down-counter timing the evaluator compute window.
//            Saturates at zero; o_zero flags the final compute cycle.
// Revision : 1.0 - initial release
// ============================================================================
module poly_feeder_counter #(
    parameter int WIDTH = 3
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_load,
    input  wire logic [WIDTH-1:0] i_load_val,
    input  wire logic             i_dec,
    output logic                  o_zero
);

    logic [WIDTH-1:0] r_count;

    // Load takes priority over decrement; never wraps below zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule : poly_feeder_counter
`default_nettype wire

// File: rtl/poly_feeder.sv
`default_nettype none
// ============================================================================
// Module   : poly_feeder
// Brief    : Accepts an {A,B,C,X} operand set, strobes each operand into an
//            external polynomial evaluator with a one-cycle Go pulse, waits
//            a fixed compute window, captures the result and holds it until
//            the consumer takes it.
// Revision : 1.0 - initial release
// ============================================================================
module poly_feeder
    import poly_pkg::*;
#(
    parameter int DATA_W         = DEFAULT_DATA_W,
    parameter int COMPUTE_CYCLES = DEFAULT_COMPUTE_CYCLES
) (
    input  wire logic   clk,
    input  wire logic   rst,
    poly_feeder_if.slave bus
);

    localparam int c_IDX_W = $clog2(NUM_OPERANDS);
    localparam int c_CNT_W = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;
    // Counter is loaded with N-1 so COMPUTE lasts exactly N cycles.
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(COMPUTE_CYCLES - 1);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_OPERANDS - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_IDX_W-1:0] r_idx;
    logic [DATA_W-1:0]  r_opnd [NUM_OPERANDS];
    logic [DATA_W-1:0]  r_result;

    logic               w_in_ready;
    logic               w_go;
    logic               w_out_valid;
    logic               w_busy;
    logic [DATA_W-1:0]  w_data_in;
    logic               w_cnt_load;
    logic               w_cnt_dec;
    logic               w_cnt_zero;

    poly_feeder_counter #(
        .WIDTH (c_CNT_W)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val (c_CNT_LOAD),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: fixed GO_HI/GO_LO pairs per operand, then compute.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (bus.in_valid) w_state_nxt = ST_GO_HI;
            ST_GO_HI:   w_state_nxt = ST_GO_LO;
            ST_GO_LO:   w_state_nxt = (r_idx == c_LAST_IDX) ? ST_COMPUTE : ST_GO_HI;
            ST_COMPUTE: if (w_cnt_zero) w_state_nxt = ST_CAPTURE;
            ST_CAPTURE: w_state_nxt = ST_HOLD;
            ST_HOLD:    if (bus.out_ready) w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode; DataIn is only driven while an operand is being loaded.
    always_comb begin
        w_in_ready  = 1'b0;
        w_go        = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b1;
        w_data_in   = '0;
        w_cnt_load  = 1'b0;
        w_cnt_dec   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b0;
            end
            ST_GO_HI: begin
                w_go      = 1'b1;
                w_data_in = r_opnd[r_idx];
            end
            ST_GO_LO: begin
                w_data_in  = r_opnd[r_idx];
                w_cnt_load = (r_idx == c_LAST_IDX);
            end
            ST_COMPUTE: w_cnt_dec   = 1'b1;
            ST_HOLD:    w_out_valid = 1'b1;
            default:    ;
        endcase
    end

    // Operand capture, operand index stepping and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx     <= '0;
            r_result  <= '0;
            r_opnd[0] <= '0;
            r_opnd[1] <= '0;
            r_opnd[2] <= '0;
            r_opnd[3] <= '0;
        end else begin
            if ((r_state == ST_IDLE) && bus.in_valid) begin
                r_opnd[0] <= bus.a;
                r_opnd[1] <= bus.b;
                r_opnd[2] <= bus.c;
                r_opnd[3] <= bus.x;
                r_idx     <= '0;
            end
            if ((r_state == ST_GO_LO) && (r_idx != c_LAST_IDX)) begin
                r_idx <= r_idx + 1'b1;
            end
            if (r_state == ST_CAPTURE) begin
                r_result <= bus.data_result;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.go        = w_go;
    assign bus.data_in   = w_data_in;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.result    = r_result;

endmodule : poly_feeder
`default_nettype wire

// File: tb/tb_poly_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_poly_feeder
// Brief    : Directed bench for poly_feeder with a behavioural evaluator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_poly_feeder;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    poly_feeder_if #(.DATA_W(8)) bus ();

    poly_feeder #(
        .DATA_W         (8),
        .COMPUTE_CYCLES (5)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Evaluator: latches A, B, C on successive Go pulses, computes on X.
    function automatic logic [7:0] poly(input logic [7:0] pa, pb, pc, px);
        logic [7:0] r;
        r = pa * px * px + pb * px + pc;
        return r;
    endfunction

    logic [7:0] ev_op [3];
    logic [1:0] ev_cnt;

    always @(posedge clk) begin
        if (rst) begin
            ev_cnt          <= 2'd0;
            bus.data_result <= 8'd0;
        end else if (bus.go) begin
            if (ev_cnt == 2'd3) begin
                bus.data_result <= poly(ev_op[0], ev_op[1], ev_op[2], bus.data_in);
                ev_cnt          <= 2'd0;
            end else begin
                ev_op[ev_cnt] <= bus.data_in;
                ev_cnt        <= ev_cnt + 2'd1;
            end
        end
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic [7:0] x;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [8];

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected outputs k cycles after the acceptance edge (k = 1..15).
    task automatic phase_chk(input int k, input logic [7:0] pa, pb, pc, px, pexp,
                             input string tag);
        logic [7:0] ops [4];
        ops = '{pa, pb, pc, px};
        chk1($sformatf("%s k=%0d go", tag, k), bus.go, (k <= 7) && (k % 2 == 1));
        if (k <= 8)
            chk8($sformatf("%s k=%0d data_in", tag, k), bus.data_in, ops[(k - 1) / 2]);
        chk1($sformatf("%s k=%0d busy", tag, k), bus.busy, 1'b1);
        chk1($sformatf("%s k=%0d in_ready", tag, k), bus.in_ready, 1'b0);
        chk1($sformatf("%s k=%0d out_valid", tag, k), bus.out_valid, k >= 15);
        if (k >= 15)
            chk8($sformatf("%s k=%0d result", tag, k), bus.result, pexp);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 50 && !bus.in_ready; i++) @(negedge clk);
        chk1($sformatf("%s idle wait", tag), bus.in_ready, 1'b1);
    endtask

    task automatic idle_chk(input string tag);
        chk1($sformatf("%s idle in_ready", tag), bus.in_ready, 1'b1);
        chk1($sformatf("%s idle out_valid", tag), bus.out_valid, 1'b0);
        chk1($sformatf("%s idle go", tag), bus.go, 1'b0);
        chk1($sformatf("%s idle busy", tag), bus.busy, 1'b0);
        chk8($sformatf("%s idle data_in", tag), bus.data_in, 8'd0);
    endtask

    // One full transaction; 'hold' extra cycles with OutReady low in HOLD.
    task automatic run_set(input logic [7:0] pa, pb, pc, px, pexp,
                           input int hold, input string tag);
        wait_idle(tag);
        bus.a = pa; bus.b = pb; bus.c = pc; bus.x = px;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k == 1) bus.in_valid = 1'b0;
            phase_chk(k, pa, pb, pc, px, pexp, tag);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            phase_chk(15, pa, pb, pc, px, pexp, $sformatf("%s hold%0d", tag, h));
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        idle_chk(tag);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen_ov;

        vecs[0] = '{a: 8'd2,   b: 8'd3,  c: 8'd4,  x: 8'd5,   exp: 8'd69};
        vecs[1] = '{a: 8'd16,  b: 8'd0,  c: 8'd0,  x: 8'd4,   exp: 8'd0};
        vecs[2] = '{a: 8'd1,   b: 8'd1,  c: 8'd1,  x: 8'd1,   exp: 8'd3};
        vecs[3] = '{a: 8'd7,   b: 8'd11, c: 8'd13, x: 8'd3,   exp: 8'd109};
        vecs[4] = '{a: 8'd255, b: 8'd1,  c: 8'd0,  x: 8'd2,   exp: 8'd254};
        vecs[5] = '{a: 8'd10,  b: 8'd20, c: 8'd30, x: 8'd40,  exp: 8'd190};
        vecs[6] = '{a: 8'd0,   b: 8'd0,  c: 8'd0,  x: 8'd0,   exp: 8'd0};
        vecs[7] = '{a: 8'd3,   b: 8'd0,  c: 8'd7,  x: 8'd255, exp: 8'd10};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = 8'd0; bus.b = 8'd0; bus.c = 8'd0; bus.x = 8'd0;
        repeat (3) @(negedge clk);
        idle_chk("reset");
        chk8("reset result", bus.result, 8'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++)
            run_set(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].x, vecs[i].exp, 0,
                    $sformatf("vec%0d", i));

        // Consumer stalls for 10 cycles in HOLD.
        run_set(8'd9, 8'd8, 8'd7, 8'd6, 8'd123, 10, "stall");

        // Back-to-back sets, InValid and OutReady held high throughout.
        wait_idle("b2b");
        bus.a = 8'd2; bus.b = 8'd3; bus.c = 8'd4; bus.x = 8'd5;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int g = 1; g <= 32; g++) begin
            @(negedge clk);
            if (g == 1) begin
                bus.a = 8'd7; bus.b = 8'd11; bus.c = 8'd13; bus.x = 8'd3;
            end
            if (g == 16 || g == 32)
                idle_chk($sformatf("b2b g=%0d", g));
            else if (g < 16)
                phase_chk(g, 8'd2, 8'd3, 8'd4, 8'd5, 8'd69, "b2b set1");
            else
                phase_chk(g - 16, 8'd7, 8'd11, 8'd13, 8'd3, 8'd109, "b2b set2");
            if (g == 31) bus.in_valid = 1'b0;
        end
        bus.out_ready = 1'b0;

        // Reset during operand C abandons the set.
        wait_idle("rst_mid");
        bus.a = 8'd9; bus.b = 8'd9; bus.c = 8'd9; bus.x = 8'd9;
        bus.in_valid = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) bus.in_valid = 1'b0;
            phase_chk(k, 8'd9, 8'd9, 8'd9, 8'd9, 8'd0, "rst_mid");
        end
        rst = 1'b1;
        @(negedge clk);
        idle_chk("rst_mid after");
        chk8("rst_mid result", bus.result, 8'd0);
        rst = 1'b0;
        seen_ov = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen_ov = 1'b1;
        end
        chk1("rst_mid no out_valid", seen_ov, 1'b0);
        run_set(8'd1, 8'd1, 8'd1, 8'd1, 8'd3, 0, "rst_fresh");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_poly_feeder
`default_nettype wire
